// File: rtl/btn_evt_gen.sv
// Push-button front end: synchronizes and debounces a raw button level, then
// emits a press pulse, optional auto-repeat pulses while held, and a release pulse.
module btn_evt_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic evt_out,
  output logic clean_out,
  output logic release_out
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  // Terminal compares are one below the limit so the counters never hold the limit itself.
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD_DELAY,
    ST_REPEATING
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_clean;
  state_t                 r_state;
  logic [RPT_W-1:0]       r_rpt_cnt;
  logic                   r_evt;
  logic                   r_rel;

  logic                   w_sync;
  logic                   w_db_diff;
  logic                   w_db_done;
  logic                   w_clean_rise;
  logic                   w_clean_fall;
  state_t                 w_state_next;
  logic [RPT_W-1:0]       w_rpt_next;
  logic                   w_evt_next;
  logic                   w_rel_next;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_sync       = r_sync[SYNC_STAGES-1];
  assign w_db_diff    = (w_sync != r_clean);
  assign w_db_done    = w_db_diff && (r_db_cnt == DB_LAST);
  assign w_clean_rise = w_db_done && !r_clean;
  assign w_clean_fall = w_db_done && r_clean;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_db_cnt <= '0;
      r_clean  <= 1'b0;
    end else if (!w_db_diff) begin
      r_db_cnt <= '0;
    end else if (w_db_done) begin
      r_db_cnt <= '0;
      r_clean  <= ~r_clean;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // Edge detection uses the debounce terminal condition, so evt/release
  // register on the same edge that clean_out changes.
  always_comb begin
    w_state_next = r_state;
    w_rpt_next   = r_rpt_cnt;
    w_evt_next   = 1'b0;
    w_rel_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clean_rise) begin
          w_evt_next   = 1'b1;
          w_rpt_next   = '0;
          w_state_next = ST_HOLD_DELAY;
        end
      end
      ST_HOLD_DELAY: begin
        if (w_clean_fall) begin
          w_rel_next   = 1'b1;
          w_rpt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (REPEAT_EN) begin
          if (r_rpt_cnt == DELAY_LAST) begin
            w_evt_next   = 1'b1;
            w_rpt_next   = '0;
            w_state_next = ST_REPEATING;
          end else begin
            w_rpt_next = r_rpt_cnt + RPT_W'(1);
          end
        end
      end
      ST_REPEATING: begin
        if (w_clean_fall) begin
          w_rel_next   = 1'b1;
          w_rpt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (r_rpt_cnt == PERIOD_LAST) begin
          w_evt_next = 1'b1;
          w_rpt_next = '0;
        end else begin
          w_rpt_next = r_rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        w_rpt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_rpt_cnt <= '0;
      r_evt     <= 1'b0;
      r_rel     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rpt_cnt <= w_rpt_next;
      r_evt     <= w_evt_next;
      r_rel     <= w_rel_next;
    end
  end

  assign evt_out     = r_evt;
  assign clean_out   = r_clean;
  assign release_out = r_rel;

endmodule
